// File: rtl/rate_pkg.sv
// Shared types and constants for the rate detector: FSM states, speed codes,
// default nominal periods and the tolerance-window helper.
package rate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        LOCKED = 2'b10
    } rd_state_t;

    localparam logic [1:0] SPD_FAST = 2'b00;
    localparam logic [1:0] SPD_1S   = 2'b01;
    localparam logic [1:0] SPD_2S   = 2'b10;
    localparam logic [1:0] SPD_4S   = 2'b11;

    localparam logic [31:0] DEF_ONE_S   = 32'd50_000_000;
    localparam logic [31:0] DEF_TWO_S   = 32'd100_000_000;
    localparam logic [31:0] DEF_FOUR_S  = 32'd200_000_000;
    localparam logic [31:0] DEF_TOL     = 32'd1024;
    localparam logic [31:0] DEF_TIMEOUT = DEF_FOUR_S + DEF_TOL;

    // True when |p - nominal| <= tol; 33-bit signed so the difference never wraps.
    function automatic logic within_tol(input logic [31:0] p,
                                        input logic [31:0] nominal,
                                        input logic [31:0] tol);
        logic signed [32:0] diff;
        diff = $signed({1'b0, p}) - $signed({1'b0, nominal});
        if (diff < 0) begin
            diff = -diff;
        end
        return (diff <= $signed({1'b0, tol}));
    endfunction

endpackage

// File: rtl/rate_detector_period_classifier.sv
// Combinational classifier: maps a measured pulse period onto the speed code
// that would have produced it, or flags it as unmatched.
module period_classifier
    import rate_pkg::*;
#(
    parameter logic [31:0] ONE_S  = DEF_ONE_S,
    parameter logic [31:0] TWO_S  = DEF_TWO_S,
    parameter logic [31:0] FOUR_S = DEF_FOUR_S,
    parameter logic [31:0] TOL    = DEF_TOL
) (
    input  logic [31:0] period_i,
    output logic [1:0]  spd_class_o,
    output logic        matched_o
);

    // A period of exactly one clock is the free-running (speed 00) stream.
    always_comb begin
        spd_class_o = SPD_FAST;
        matched_o   = 1'b0;
        if (period_i == 32'd1) begin
            spd_class_o = SPD_FAST;
            matched_o   = 1'b1;
        end else if (within_tol(period_i, ONE_S, TOL)) begin
            spd_class_o = SPD_1S;
            matched_o   = 1'b1;
        end else if (within_tol(period_i, TWO_S, TOL)) begin
            spd_class_o = SPD_2S;
            matched_o   = 1'b1;
        end else if (within_tol(period_i, FOUR_S, TOL)) begin
            spd_class_o = SPD_4S;
            matched_o   = 1'b1;
        end
    end

endmodule

// File: rtl/rate_detector.sv
// Rate detector: measures the interval between divider enable pulses, locks
// once two consecutive intervals fall in the same speed class, flags loss of
// lock, and mirrors the transmitter's 4-bit pulse counter.
module rate_detector
    import rate_pkg::*;
#(
    parameter logic [31:0] ONE_S   = DEF_ONE_S,
    parameter logic [31:0] TWO_S   = DEF_TWO_S,
    parameter logic [31:0] FOUR_S  = DEF_FOUR_S,
    parameter logic [31:0] TOL     = DEF_TOL,
    parameter logic [31:0] TIMEOUT = FOUR_S + TOL
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       PulseIn,
    output logic [1:0] SpeedOut,
    output logic       Locked,
    output logic       Error,
    output logic [3:0] PulseCount
);

    rd_state_t   state_q;
    logic [31:0] int_cnt_q;
    logic [31:0] int_cnt_d;
    logic [31:0] period_d;
    logic [1:0]  cand_q;
    logic        cand_valid_q;
    logic [1:0]  speed_q;
    logic        locked_q;
    logic        error_q;
    logic [3:0]  pulse_cnt_q;
    logic [1:0]  cls;
    logic        matched;
    logic        timeout_hit;

    // Period includes the pulse cycle itself, so back-to-back pulses give 1.
    assign period_d = int_cnt_q + 32'd1;

    // A pulse on the saturation cycle takes priority over the timeout.
    assign timeout_hit = (int_cnt_q == TIMEOUT) && !PulseIn;

    period_classifier #(
        .ONE_S  (ONE_S),
        .TWO_S  (TWO_S),
        .FOUR_S (FOUR_S),
        .TOL    (TOL)
    ) u_classifier (
        .period_i    (period_d),
        .spd_class_o (cls),
        .matched_o   (matched)
    );

    // Interval counter next state: restart on a pulse, otherwise count up and saturate.
    always_comb begin
        int_cnt_d = int_cnt_q;
        if (PulseIn) begin
            int_cnt_d = 32'd0;
        end else if (int_cnt_q != TIMEOUT) begin
            int_cnt_d = int_cnt_q + 32'd1;
        end
    end

    // Interval counter register.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            int_cnt_q <= 32'd0;
        end else begin
            int_cnt_q <= int_cnt_d;
        end
    end

    // Received-pulse counter, counts in every state and wraps naturally at 16.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            pulse_cnt_q <= 4'd0;
        end else if (PulseIn) begin
            pulse_cnt_q <= pulse_cnt_q + 4'd1;
        end
    end

    // Lock FSM with candidate tracking and registered status outputs.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q      <= IDLE;
            cand_q       <= SPD_FAST;
            cand_valid_q <= 1'b0;
            speed_q      <= SPD_FAST;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // First pulse only starts a measurement; there is no period yet.
                    if (PulseIn) begin
                        state_q      <= ARMED;
                        cand_valid_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (PulseIn) begin
                        if (matched && cand_valid_q && (cls == cand_q)) begin
                            state_q  <= LOCKED;
                            speed_q  <= cls;
                            locked_q <= 1'b1;
                        end else begin
                            cand_q       <= cls;
                            cand_valid_q <= matched;
                        end
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                    end
                end
                LOCKED: begin
                    if (PulseIn) begin
                        // Any pulse that does not confirm the locked class drops lock;
                        // a matched new class becomes the next candidate.
                        if (!(matched && (cls == speed_q))) begin
                            error_q      <= 1'b1;
                            state_q      <= ARMED;
                            speed_q      <= SPD_FAST;
                            locked_q     <= 1'b0;
                            cand_q       <= cls;
                            cand_valid_q <= matched;
                        end
                    end else if (timeout_hit) begin
                        error_q  <= 1'b1;
                        state_q  <= IDLE;
                        speed_q  <= SPD_FAST;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SpeedOut   = speed_q;
    assign Locked     = locked_q;
    assign Error      = error_q;
    assign PulseCount = pulse_cnt_q;

endmodule

// File: tb/tb_rate_detector.sv
// Directed testbench for rate_detector with scaled-down periods
// (ONE_S=10, TWO_S=20, FOUR_S=40, TOL=2, TIMEOUT=42).
module tb_rate_detector;

    logic       ClockIn;
    logic       Reset;
    logic       PulseIn;
    logic [1:0] SpeedOut;
    logic       Locked;
    logic       Error;
    logic [3:0] PulseCount;

    int n_checks;
    int n_pass;
    int err_cycles;

    rate_detector #(
        .ONE_S   (32'd10),
        .TWO_S   (32'd20),
        .FOUR_S  (32'd40),
        .TOL     (32'd2),
        .TIMEOUT (32'd42)
    ) dut (
        .ClockIn    (ClockIn),
        .Reset      (Reset),
        .PulseIn    (PulseIn),
        .SpeedOut   (SpeedOut),
        .Locked     (Locked),
        .Error      (Error),
        .PulseCount (PulseCount)
    );

    initial begin
        ClockIn = 1'b0;
        forever #5 ClockIn = ~ClockIn;
    end

    // Count Error-high cycles away from the active edge.
    initial err_cycles = 0;
    always @(negedge ClockIn) begin
        if (Error === 1'b1) begin
            err_cycles = err_cycles + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
            $display("check %-22s got %0d expected %0d ok", tag, obs, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; afterwards outputs reflect that edge.
    task automatic tick();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic pulse();
        PulseIn = 1'b1;
        tick();
        PulseIn = 1'b0;
    endtask

    // Next pulse lands k cycles after the previous one.
    task automatic pulse_after(input int k);
        idle(k - 1);
        pulse();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic lk, input logic [1:0] spd,
                                 input logic er);
        check_val({tag, ".locked"}, {31'd0, Locked}, {31'd0, lk});
        check_val({tag, ".speed"}, {30'd0, SpeedOut}, {30'd0, spd});
        check_val({tag, ".error"}, {31'd0, Error}, {31'd0, er});
    endtask

    initial begin
        int e0;
        n_checks = 0;
        n_pass   = 0;
        Reset    = 1'b1;
        PulseIn  = 1'b0;
        tick();
        tick();
        check_outputs("reset", 1'b0, 2'b00, 1'b0);
        check_val("reset.pcount", {28'd0, PulseCount}, 32'd0);
        Reset = 1'b0;
        tick();

        // Continuous pulses: lock on the third.
        pulse();
        pulse();
        check_val("fast.not_yet", {31'd0, Locked}, 32'd0);
        pulse();
        check_outputs("fast", 1'b1, 2'b00, 1'b0);
        check_val("fast.pcount", {28'd0, PulseCount}, 32'd3);
        do_reset();

        // Period 20 -> class 10.
        pulse();
        pulse_after(20);
        check_val("p20.not_yet", {31'd0, Locked}, 32'd0);
        pulse_after(20);
        check_outputs("p20", 1'b1, 2'b10, 1'b0);
        do_reset();

        // Period 11 -> class 01 (inside tolerance).
        pulse();
        pulse_after(11);
        pulse_after(11);
        check_outputs("p11", 1'b1, 2'b01, 1'b0);
        do_reset();

        // Period 13 never matches.
        pulse();
        for (int i = 0; i < 4; i++) begin
            pulse_after(13);
        end
        check_outputs("p13", 1'b0, 2'b00, 1'b0);
        check_val("p13.pcount", {28'd0, PulseCount}, 32'd5);
        do_reset();

        // Lock at 01, then change to 20.
        pulse();
        pulse_after(10);
        pulse_after(10);
        check_outputs("p10", 1'b1, 2'b01, 1'b0);
        pulse_after(20);
        check_outputs("chg.err", 1'b0, 2'b00, 1'b1);
        tick();
        check_val("chg.err_one", {31'd0, Error}, 32'd0);
        idle(18);
        pulse();
        check_outputs("chg.relock", 1'b1, 2'b10, 1'b0);
        do_reset();

        // Lock at 11, then let it time out.
        pulse();
        pulse_after(40);
        pulse_after(40);
        check_outputs("p40", 1'b1, 2'b11, 1'b0);
        idle(42);
        check_outputs("to.before", 1'b1, 2'b11, 1'b0);
        tick();
        check_outputs("to.fire", 1'b0, 2'b00, 1'b1);
        tick();
        check_val("to.err_one", {31'd0, Error}, 32'd0);

        // Re-lock from IDLE, then pulse exactly on the timeout cycle.
        pulse();
        pulse_after(40);
        pulse_after(40);
        check_outputs("p40b", 1'b1, 2'b11, 1'b0);
        pulse_after(43);
        check_outputs("to.pulse", 1'b0, 2'b00, 1'b1);
        tick();
        check_val("to.pulse_one", {31'd0, Error}, 32'd0);
        do_reset();

        // 17 pulses wrap the counter to 1; then reset while locked.
        for (int i = 0; i < 17; i++) begin
            pulse();
        end
        check_val("wrap.pcount", {28'd0, PulseCount}, 32'd1);
        check_val("wrap.locked", {31'd0, Locked}, 32'd1);
        e0 = err_cycles;
        Reset = 1'b1;
        tick();
        check_outputs("rst_lock", 1'b0, 2'b00, 1'b0);
        check_val("rst_lock.pcount", {28'd0, PulseCount}, 32'd0);
        Reset = 1'b0;
        tick();
        check_val("rst_lock.noerr", {31'd0, Error}, 32'd0);
        check_val("rst_lock.errcnt", err_cycles, e0);

        // Total Error-high cycles over the run: change, timeout, pulse-on-timeout.
        check_val("err_total", err_cycles, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rate_detector.md
# rate_detector

Receive-side companion to the speed-selectable rate divider. It watches the one-cycle enable pulse stream that the divider produces and measures the interval between pulses. Each interval is classified into the 2-bit speed code that generated it, and the detector locks once two consecutive intervals agree. It also keeps a 4-bit wrapping count of received pulses that mirrors the transmitter's counter. It sits downstream of the divider: on-board it drives HEX/LED status, and in simulation it is the checker's monitor.

## Interface
- ONE_S, 50000000, nominal period in clocks for speed 01
- TWO_S, 100000000, nominal period in clocks for speed 10
- FOUR_S, 200000000, nominal period in clocks for speed 11
- TOL, 1024, allowed ± deviation in clocks per class; constraint TOL < ONE_S/2
- TIMEOUT, FOUR_S+TOL, number of clocks without a pulse before lock is dropped
- ClockIn  input  1  clock; all state updates on the rising edge
- Reset  input  1  reset Reset, synchronous, active-high; clock ClockIn
- PulseIn  input  1  one-cycle enable pulse from the divider; may be high on consecutive cycles
- SpeedOut  output  2  locked speed code; 00 whenever Locked=0
- Locked  output  1  high while the stream matches a single class
- Error  output  1  one-cycle pulse when lock is lost
- PulseCount  output  4  number of PulseIn cycles seen, mod 16

## Operation
- Interval counter IntCnt (32-bit):
  - On a PulseIn cycle: measured period P = IntCnt+1, then IntCnt <= 0.
  - Otherwise IntCnt increments, saturating at TIMEOUT.
- Classification of P (combinational):
  - P==1 gives 00.
  - |P−ONE_S| ≤ TOL gives 01.
  - |P−TWO_S| ≤ TOL gives 10.
  - |P−FOUR_S| ≤ TOL gives 11.
  - Anything else is unmatched.
  - Use 33-bit signed arithmetic for the differences.
- States: IDLE, ARMED, LOCKED. Registers Cand[1:0] and CandValid hold the candidate class.
- IDLE:
  - PulseIn goes to ARMED. No period is measured; CandValid <= 0.
  - No other activity.
- ARMED:
  - PulseIn with P matched, CandValid=1 and class==Cand goes to LOCKED; SpeedOut <= class.
  - PulseIn otherwise stays in ARMED; Cand <= class, CandValid <= matched.
  - IntCnt reaching TIMEOUT goes to IDLE; no Error.
- LOCKED:
  - PulseIn with the same class stays in LOCKED.
  - PulseIn with a different matched class: Error, go to ARMED, Cand <= new class, CandValid <= 1.
  - PulseIn with an unmatched period: Error, go to ARMED, CandValid <= 0.
  - IntCnt reaching TIMEOUT with no pulse: Error, go to IDLE.
  - Every exit from LOCKED clears SpeedOut to 00.
- PulseCount increments on every PulseIn cycle in every state and wraps 15→0.

## Timing
- Reset dominates all other inputs. Reset values:
  - state=IDLE, IntCnt=0, Cand=00, CandValid=0
  - SpeedOut=00, Locked=0, Error=0, PulseCount=0
- All outputs are registered.
  - Locked and SpeedOut update on the edge that samples the third pulse (second matching interval). They are visible the following cycle.
  - Error is high for exactly one cycle, in the cycle after the offending pulse or timeout edge.
- PulseIn in the same cycle IntCnt reaches TIMEOUT: the pulse wins. P=TIMEOUT+1 is unmatched, so LOCKED raises Error and goes to ARMED.
- Continuous PulseIn (divider speed 00) gives P=1 every cycle and locks after 3 cycles.
- PulseCount lags PulseIn by one cycle.
- Reset mid-LOCKED: outputs take reset values next cycle, with no Error pulse.

## Structure
- Package rate_pkg holds:
  - the state enum (IDLE, ARMED, LOCKED)
  - speed code constants SPD_FAST=00, SPD_1S=01, SPD_2S=10, SPD_4S=11
  - the default period constants
- One sub-module, period_classifier:
  - combinational
  - inputs P[31:0]; outputs class[1:0] and matched
  - parameterised by ONE_S/TWO_S/FOUR_S/TOL
- Top level holds IntCnt, the FSM, the candidate registers and PulseCount.

## Test plan
Parameters for all scenarios: ONE_S=10, TWO_S=20, FOUR_S=40, TOL=2, TIMEOUT=42.
- Pulses at cycles 0,1,2 → Locked=1 and SpeedOut=00 from cycle 3, PulseCount=3, Error never high.
- Pulses at 0,20,40 → Locked=1, SpeedOut=10 after the third pulse. Repeat with period 11 → SpeedOut=01.
- Period 13 repeated 5 times → Locked stays 0, Error stays 0, PulseCount=5.
- Locked at 01 (period 10), then one interval of 20 → Error high one cycle, Locked=0, SpeedOut=00. One more 20 interval → Locked=1, SpeedOut=10.
- Locked at 11, then no pulses → IDLE at IntCnt=42 with a one-cycle Error, Locked=0. A pulse exactly on the timeout cycle → Error, state ARMED.
- 17 pulses → PulseCount wraps to 1. Reset asserted while LOCKED → all outputs 0 the next cycle, Error=0.
